// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: two requester handshakes plus
// the single downstream memory handshake. The arbiter uses the slave view;
// the surrounding system (CPU ports and memory model) uses the master view.
interface memory_bus_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     port0_request;
    logic [ADDRESS_WIDTH-1:0] port0_address;
    logic                     port0_write_enable;
    logic [DATA_WIDTH-1:0]    port0_write_data;
    logic                     port0_ready;
    logic [DATA_WIDTH-1:0]    port0_read_data;
    logic                     port0_error;

    logic                     port1_request;
    logic [ADDRESS_WIDTH-1:0] port1_address;
    logic                     port1_write_enable;
    logic [DATA_WIDTH-1:0]    port1_write_data;
    logic                     port1_ready;
    logic [DATA_WIDTH-1:0]    port1_read_data;
    logic                     port1_error;

    logic                     mem_request;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic                     mem_write_enable;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    modport slave (
        input  port0_request, port0_address, port0_write_enable, port0_write_data,
        output port0_ready, port0_read_data, port0_error,
        input  port1_request, port1_address, port1_write_enable, port1_write_data,
        output port1_ready, port1_read_data, port1_error,
        output mem_request, mem_address, mem_write_enable, mem_write_data,
        input  mem_ready, mem_read_data
    );

    modport master (
        output port0_request, port0_address, port0_write_enable, port0_write_data,
        input  port0_ready, port0_read_data, port0_error,
        output port1_request, port1_address, port1_write_enable, port1_write_data,
        input  port1_ready, port1_read_data, port1_error,
        input  mem_request, mem_address, mem_write_enable, mem_write_data,
        output mem_ready, mem_read_data
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-port round-robin arbiter for a single request/ready memory bus.
// One access at a time: IDLE grants, ACCESS waits for mem_ready (or the
// timeout), RESPOND pulses the winner's ready for one cycle.
module memory_bus_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_bus_arbiter_if.slave   bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic                     write_enable;
        logic [DATA_WIDTH-1:0]    write_data;
    } request_t;

    state_t                          state;
    logic                            grant;
    logic                            last_served;
    logic [CW-1:0]                   cnt;
    logic [1:0]                      ready;
    logic [1:0]                      error;
    logic [1:0][DATA_WIDTH-1:0]      read_data;

    logic [1:0]                      req_valid;
    request_t [1:0]                  req_payload;
    logic                            pick;
    logic                            timeout_hit;

    assign req_valid      = {bus.port1_request, bus.port0_request};
    assign req_payload[0] = {bus.port0_address, bus.port0_write_enable, bus.port0_write_data};
    assign req_payload[1] = {bus.port1_address, bus.port1_write_enable, bus.port1_write_data};

    // Lone requester wins; on a tie the port that was not served last wins.
    assign pick = (req_valid == 2'b11) ? ~last_served : req_valid[1];

    // Abort on the edge that would bring the count up to TIMEOUT, so the bus
    // sees exactly TIMEOUT cycles of ACCESS.
    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt) + 1) == TIMEOUT);

    assign bus.port0_ready     = ready[0];
    assign bus.port1_ready     = ready[1];
    assign bus.port0_error     = error[0];
    assign bus.port1_error     = error[1];
    assign bus.port0_read_data = read_data[0];
    assign bus.port1_read_data = read_data[1];

    // Arbitration FSM; every output is a register so the memory side sees
    // a stable, glitch-free command for the whole access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            grant                <= 1'b0;
            last_served          <= 1'b1;
            cnt                  <= '0;
            ready                <= '0;
            error                <= '0;
            read_data            <= '0;
            bus.mem_request      <= 1'b0;
            bus.mem_address      <= '0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant                <= pick;
                        bus.mem_request      <= 1'b1;
                        bus.mem_address      <= req_payload[pick].address;
                        bus.mem_write_enable <= req_payload[pick].write_enable;
                        bus.mem_write_data   <= req_payload[pick].write_data;
                        cnt                  <= '0;
                        state                <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready || timeout_hit) begin
                        // Completion beats a simultaneous timeout.
                        read_data[grant]     <= (bus.mem_ready && !bus.mem_write_enable)
                                                ? bus.mem_read_data : '0;
                        error[grant]         <= !bus.mem_ready;
                        ready[grant]         <= 1'b1;
                        last_served          <= grant;
                        bus.mem_request      <= 1'b0;
                        bus.mem_write_enable <= 1'b0;
                        state                <= RESPOND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESPOND: begin
                    // Requests are ignored here so a held request is not re-granted.
                    ready     <= '0;
                    error     <= '0;
                    read_data <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter (TIMEOUT=4). Inputs are driven and
// outputs sampled 1ns after each rising edge.
module tb_memory_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    memory_bus_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_bus_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two ready pulses in one cycle would mean both ports were granted.
    always @(negedge clock) begin
        if (reset) begin
            n_checks++;
            assert (!(bus.port0_ready === 1'b1 && bus.port1_ready === 1'b1)) else begin
                n_fail++;
                $error("FAIL both_ready: observed 11 expected not both");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.port0_request = 0; bus.port0_address = 0; bus.port0_write_enable = 0; bus.port0_write_data = 0;
        bus.port1_request = 0; bus.port1_address = 0; bus.port1_write_enable = 0; bus.port1_write_data = 0;
        bus.mem_ready = 0; bus.mem_read_data = 0;

        // Reset state
        #2;
        chk("rst_mem_request", bus.mem_request, 0);
        chk("rst_mem_we", bus.mem_write_enable, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_p0_ready", bus.port0_ready, 0);
        chk("rst_p1_ready", bus.port1_ready, 0);
        chk("rst_p0_data", bus.port0_read_data, 0);
        step(); step();
        reset = 1;

        // Single read from port 0, memory answers after 3 ACCESS cycles
        bus.port0_request = 1; bus.port0_address = 32'h100; bus.port0_write_enable = 0;
        step();
        chk("rd_mem_request", bus.mem_request, 1);
        chk("rd_mem_address", bus.mem_address, 32'h100);
        chk("rd_mem_we", bus.mem_write_enable, 0);
        chk("rd_p0_ready_early", bus.port0_ready, 0);
        step(); step();
        chk("rd_mem_request_hold", bus.mem_request, 1);
        chk("rd_mem_address_hold", bus.mem_address, 32'h100);
        chk("rd_mem_we_hold", bus.mem_write_enable, 0);
        bus.mem_ready = 1; bus.mem_read_data = 32'hDEADBEEF;
        step();
        chk("rd_p0_ready", bus.port0_ready, 1);
        chk("rd_p0_data", bus.port0_read_data, 32'hDEADBEEF);
        chk("rd_p0_error", bus.port0_error, 0);
        chk("rd_p1_ready", bus.port1_ready, 0);
        chk("rd_mem_request_drop", bus.mem_request, 0);
        bus.port0_request = 0; bus.mem_ready = 0;
        step();
        chk("rd_p0_ready_clear", bus.port0_ready, 0);
        chk("rd_p0_data_clear", bus.port0_read_data, 0);

        // Tie and round-robin from a fresh reset: port 0 first, then alternating
        reset = 0; #4; reset = 1;
        bus.port0_request = 1; bus.port0_address = 32'h300; bus.port0_write_enable = 0;
        bus.port1_request = 1; bus.port1_address = 32'h200; bus.port1_write_enable = 1;
        bus.port1_write_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            logic exp_port;
            exp_port = i[0];
            step();
            chk("rr_mem_request", bus.mem_request, 1);
            chk("rr_mem_address", bus.mem_address, exp_port ? 64'h200 : 64'h300);
            chk("rr_mem_we", bus.mem_write_enable, {63'd0, exp_port});
            if (exp_port) chk("rr_mem_wdata", bus.mem_write_data, 32'h55);
            bus.mem_ready = 1; bus.mem_read_data = 32'hA0 + i;
            step();
            chk("rr_p0_ready", bus.port0_ready, {63'd0, !exp_port});
            chk("rr_p1_ready", bus.port1_ready, {63'd0, exp_port});
            if (!exp_port) chk("rr_p0_data", bus.port0_read_data, 32'hA0 + i);
            else           chk("rr_p1_data", bus.port1_read_data, 0);
            chk("rr_mem_we_drop", bus.mem_write_enable, 0);
            bus.mem_ready = 0;
            step();
            chk("rr_idle_gap", bus.mem_request, 0);
        end
        bus.port0_request = 0; bus.port1_request = 0; bus.port1_write_enable = 0;

        // Timeout on a port 1 read; stale mem_read_data must not leak through
        bus.mem_read_data = 32'h12345678;
        bus.port1_request = 1; bus.port1_address = 32'h400;
        step();
        chk("to_mem_request", bus.mem_request, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_mem_request_hold", bus.mem_request, 1);
            chk("to_p1_ready_early", bus.port1_ready, 0);
        end
        step();
        chk("to_mem_request_drop", bus.mem_request, 0);
        chk("to_p1_ready", bus.port1_ready, 1);
        chk("to_p1_error", bus.port1_error, 1);
        chk("to_p1_data", bus.port1_read_data, 0);
        bus.port1_request = 0;
        step();
        chk("to_p1_error_clear", bus.port1_error, 0);
        bus.port0_request = 1; bus.port0_address = 32'h500;
        step();
        chk("to_next_address", bus.mem_address, 32'h500);
        bus.mem_ready = 1; bus.mem_read_data = 32'hCAFEF00D;
        step();
        chk("to_next_p0_ready", bus.port0_ready, 1);
        chk("to_next_p0_error", bus.port0_error, 0);
        chk("to_next_p0_data", bus.port0_read_data, 32'hCAFEF00D);
        bus.port0_request = 0; bus.mem_ready = 0;
        step();

        // mem_ready on the same edge the count reaches TIMEOUT: completion wins
        bus.port1_request = 1; bus.port1_address = 32'h600;
        step();
        step(); step(); step();
        chk("col_mem_request_hold", bus.mem_request, 1);
        bus.mem_ready = 1; bus.mem_read_data = 32'h0BADC0DE;
        step();
        chk("col_p1_ready", bus.port1_ready, 1);
        chk("col_p1_error", bus.port1_error, 0);
        chk("col_p1_data", bus.port1_read_data, 32'h0BADC0DE);
        bus.port1_request = 0; bus.mem_ready = 0;
        step();

        // Asynchronous reset in the middle of an access
        bus.port0_request = 1; bus.port0_address = 32'h700;
        step();
        step();
        chk("ra_mem_request", bus.mem_request, 1);
        #2 reset = 0;
        #1;
        chk("ra_mem_request_drop", bus.mem_request, 0);
        chk("ra_mem_address_zero", bus.mem_address, 0);
        chk("ra_p0_ready", bus.port0_ready, 0);
        chk("ra_p1_ready", bus.port1_ready, 0);
        chk("ra_p0_error", bus.port0_error, 0);
        bus.port1_request = 1; bus.port1_address = 32'h800;
        #2 reset = 1;
        step();
        chk("ra_tie_grant", bus.mem_address, 32'h700);
        bus.mem_ready = 1; bus.mem_read_data = 32'h77;
        step();
        chk("ra_p0_done", bus.port0_ready, 1);
        chk("ra_p1_wait", bus.port1_ready, 0);
        bus.port0_request = 0; bus.mem_ready = 0;
        step();
        step();
        chk("ra_p1_grant", bus.mem_address, 32'h800);
        bus.mem_ready = 1; bus.mem_read_data = 32'h88;
        step();
        chk("ra_p1_done", bus.port1_ready, 1);
        chk("ra_p1_data", bus.port1_read_data, 32'h88);
        bus.port1_request = 0; bus.mem_ready = 0;
        step();

        // Request held through its own ready cycle is served exactly once
        bus.port0_request = 1; bus.port0_address = 32'h900;
        step();
        bus.mem_ready = 1; bus.mem_read_data = 32'h11;
        step();
        chk("hold_p0_ready", bus.port0_ready, 1);
        bus.mem_ready = 0;
        step();
        chk("hold_no_regrant", bus.mem_request, 0);
        chk("hold_p0_ready_clear", bus.port0_ready, 0);
        bus.port0_request = 0;
        step();
        chk("hold_idle_1", bus.mem_request, 0);
        step();
        chk("hold_idle_2", bus.mem_request, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
